load_store_unit: RTL and testbench

- Sits between the single-cycle datapath's memory port (mem_addr, rt store data) and the byte-laned data memory.
- Accepts one load/store request at a time and performs natural-alignment checking.
- Converts between 32-bit register values and 4 big-endian 8-bit memory lanes. Lane 0 = bits 31:24.
- Runs a request/acknowledge handshake with a variable-latency memory, so the datapath can stall on busy.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_lane_align.sv | 48 ++++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// lane count and the natural-alignment check.
package lsu_pkg;

    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    // Size 2'b11 is not a legal encoding and is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering between 32-bit register values and four
// big-endian byte lanes (lane 0 = bits 31:24).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]             size,
    input  logic [1:0]             offset,
    input  logic                   sign_ext,
    input  logic [31:0]            wdata,
    input  logic [0:LANES-1][7:0]  rd_lanes,
    output logic [LANES-1:0]       be,
    output logic [0:LANES-1][7:0]  wr_lanes,
    output logic [31:0]            rdata
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // offset + 1 wraps for offset 3, but halves are only used when aligned.
    assign rd_byte = rd_lanes[offset];
    assign rd_half = {rd_lanes[offset], rd_lanes[offset + 2'd1]};

    always_comb begin
        be       = '0;
        wr_lanes = '0;
        rdata    = '0;
        case (size)
            SZ_BYTE: begin
                be[offset] = 1'b1;
                wr_lanes   = {4{wdata[7:0]}};
                rdata      = {{24{sign_ext & rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                be[offset]        = 1'b1;
                be[offset + 2'd1] = 1'b1;
                wr_lanes          = {2{wdata[15:0]}};
                rdata             = {{16{sign_ext & rd_half[15]}}, rd_half};
            end
            SZ_WORD: begin
                be       = '1;
                wr_lanes = wdata;
                rdata    = rd_lanes;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: alignment check, lane packing and req/ack handshake with a
// variable-latency byte-laned memory. Define LSU_TIMEOUT_EN for an ACCESS timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
`ifdef LSU_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_signed,
    input  logic [XLEN-1:0]        req_addr,
    input  logic [XLEN-1:0]        req_wdata,
    output logic                   resp_valid,
    output logic [XLEN-1:0]        resp_rdata,
    output logic                   resp_err,
    output logic                   busy,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [XLEN-1:0]        mem_addr,
    output logic [LANES-1:0]       mem_be,
    output logic [0:LANES-1][7:0]  mem_data_in,
    input  logic [0:LANES-1][7:0]  mem_data_out,
    input  logic                   mem_ack
);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   addr_q, wdata_q, rdata_q;
    logic [1:0]        size_q;
    logic              sign_q, we_q, err_q;

    logic              accept, req_bad, in_access, timeout;
    logic [LANES-1:0]  be_w;
    logic [0:LANES-1][7:0] wr_lanes_w;
    logic [XLEN-1:0]   load_w;

    assign accept    = req_valid && (state_q == IDLE);
    assign req_bad   = is_misaligned(req_size, req_addr[1:0]);
    assign in_access = (state_q == ACCESS);

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CntW-1:0] cnt_q;

    // Terminal cycle is the TIMEOUT_CYCLES-th ACCESS cycle; an ack there still wins.
    assign timeout = in_access && !mem_ack && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (in_access && !mem_ack) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    lsu_lane_align u_lane_align (
        .size     (size_q),
        .offset   (addr_q[1:0]),
        .sign_ext (sign_q),
        .wdata    (wdata_q),
        .rd_lanes (mem_data_out),
        .be       (be_w),
        .wr_lanes (wr_lanes_w),
        .rdata    (load_w)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = req_bad ? RESP : ACCESS;
            ACCESS:  if (mem_ack || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                sign_q  <= req_signed;
                we_q    <= req_we;
                if (req_bad) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end
            end
            if (in_access && mem_ack) begin
                err_q   <= 1'b0;
                rdata_q <= we_q ? '0 : load_w;
            end else if (timeout) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

    // Memory-side outputs are forced to zero outside ACCESS.
    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign resp_valid  = (state_q == RESP);
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign mem_req     = in_access;
    assign mem_we      = in_access && we_q;
    assign mem_addr    = in_access ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_be      = in_access ? be_w : '0;
    assign mem_data_in = in_access ? wr_lanes_w : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions compared against an arithmetic reference model.
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_b;
    logic              req_valid, req_ready, req_we, req_signed;
    logic [1:0]        req_size;
    logic [31:0]       req_addr, req_wdata;
    logic              resp_valid, resp_err, busy;
    logic [31:0]       resp_rdata;
    logic              mem_req, mem_we, mem_ack;
    logic [31:0]       mem_addr;
    logic [3:0]        mem_be;
    logic [0:3][7:0]   mem_data_in, mem_data_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
`else
    load_store_unit #(.XLEN(32)) dut (
`endif
        .clk          (clk),
        .rst_b        (rst_b),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .busy         (busy),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_ack      (mem_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a full request/response transaction. ack_at = ACCESS cycle
    // carrying mem_ack (0 = never, only meaningful with the timeout feature).
    task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] lanes, input int ack_at);
        int          k;
        bit          mis;
        bit          timed_out;
        int          n_access;
        int          busy_n;
        int          c;
        bit          done;
        logic [31:0] aligned, mask, exp_rd, v, din;
        logic [3:0]  exp_be;
        logic        exp_err;

        k   = int'(addr[1:0]);
        mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && k != 0);
        timed_out = !mis && (ack_at == 0);
        n_access  = mis ? 0 : (timed_out ? TO : ack_at);

        aligned = 32'h0;
        exp_be  = 4'h0;
        v       = 32'h0;
        case (size)
            2'd0: begin
                aligned = {24'h0, wdata[7:0]} << (8 * (3 - k));
                exp_be  = 4'b0001 << k;
                v = (lanes >> (8 * (3 - k))) & 32'hFF;
                if (sgn && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                aligned = {16'h0, wdata[15:0]} << (8 * (2 - k));
                exp_be  = 4'b0011 << k;
                v = (lanes >> (8 * (2 - k))) & 32'hFFFF;
                if (sgn && v[15]) v = v | 32'hFFFF_0000;
            end
            2'd2: begin
                aligned = wdata;
                exp_be  = 4'hF;
                v       = lanes;
            end
            default: ;
        endcase
        mask = 32'h0;
        for (int j = 0; j < 4; j++) if (exp_be[j]) mask[31 - 8 * j -: 8] = 8'hFF;
        exp_err = mis || timed_out;
        exp_rd  = (we || exp_err) ? 32'h0 : v;

        check_eq("req_ready_idle", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        step();
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;

        busy_n = 0;
        c      = 0;
        done   = mis;
        while (!done) begin
            c++;
            busy_n += int'(busy);
            check_eq("mem_req", mem_req, 1'b1);
            check_eq("mem_addr", mem_addr, {addr[31:2], 2'b00});
            check_eq("mem_we", mem_we, we);
            check_eq("mem_be", mem_be, exp_be);
            check_eq("resp_valid_wait", resp_valid, 1'b0);
            if (we) begin
                din = mem_data_in;
                check_eq("store_lanes", din & mask, aligned & mask);
            end
            if (c == ack_at) begin
                mem_ack      = 1'b1;
                mem_data_out = lanes;
            end else begin
                mem_ack      = 1'b0;
                mem_data_out = $urandom;
            end
            step();
            mem_ack = 1'b0;
            if (c == ack_at || (TO != 0 && c == TO)) done = 1'b1;
        end

        busy_n += int'(busy);
        check_eq("resp_valid", resp_valid, 1'b1);
        check_eq("resp_err", resp_err, exp_err);
        check_eq("resp_rdata", resp_rdata, exp_rd);
        check_eq("mem_req_resp", mem_req, 1'b0);
        check_eq("req_ready_resp", req_ready, 1'b0);
        step();
        check_eq("resp_valid_pulse", resp_valid, 1'b0);
        check_eq("busy_after", busy, 1'b0);
        check_eq("rdata_hold", resp_rdata, exp_rd);
        check_eq("err_hold", resp_err, exp_err);
        check_eq("busy_cycles", busy_n, n_access + 1);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          ack;

        rst_b        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_signed   = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        mem_ack      = 1'b0;
        mem_data_out = 32'h0;
        step();
        step();
        check_eq("rst_ready", req_ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_resp_valid", resp_valid, 1'b0);
        check_eq("rst_rdata", resp_rdata, 32'h0);
        check_eq("rst_err", resp_err, 1'b0);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        rst_b = 1'b1;
        step();

        // Directed cases
        run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
        run_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h11223380, 1);
        run_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h11223380, 2);
        run_txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h12345678, 32'h0, 1);
        run_txn(1'b0, 2'd1, 1'b1, 32'h300, 32'h0, 32'h9ABC0000, 1);
        run_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 1);
        run_txn(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1);
`ifdef LSU_TIMEOUT_EN
        run_txn(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'hCAFEF00D, 0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'hCAFEF00D, TO);
`endif

        // Reset in the middle of ACCESS; a late ack must be ignored
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h500;
        step();
        req_valid = 1'b0;
        check_eq("mid_access_req", mem_req, 1'b1);
        step();
        rst_b = 1'b0;
        step();
        check_eq("mid_rst_mem_req", mem_req, 1'b0);
        check_eq("mid_rst_ready", req_ready, 1'b1);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_err", resp_err, 1'b0);
        rst_b        = 1'b1;
        mem_ack      = 1'b1;
        mem_data_out = 32'h12345678;
        step();
        mem_ack = 1'b0;
        check_eq("late_ack_no_resp", resp_valid, 1'b0);
        step();
        check_eq("late_ack_no_resp2", resp_valid, 1'b0);
        check_eq("late_ack_rdata", resp_rdata, 32'h0);

        // Randomized transactions
        for (int i = 0; i < 200; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            if (TO != 0) ack = $urandom_range(0, TO);
            else         ack = $urandom_range(1, 6);
            run_txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, ack);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
